// File: rtl/io_bus_arbiter_if.sv
// IO bus arbiter bundle: per-master request lines, shared bus lines, slave response.
// Latency: none, this is wiring only.
// Backpressure: masters hold m_req until m_ack; the slave stalls the bus by withholding s_ack.
interface io_bus_arbiter_if #(
    parameter int NR_OF_MASTERS = 2
);
    logic [NR_OF_MASTERS-1:0]    m_req;
    logic [NR_OF_MASTERS-1:0]    m_we;
    logic [NR_OF_MASTERS-1:0]    m_re;
    logic [NR_OF_MASTERS*32-1:0] m_addr;
    logic [NR_OF_MASTERS*32-1:0] m_wdata;
    logic [NR_OF_MASTERS-1:0]    m_gnt;
    logic [NR_OF_MASTERS-1:0]    m_ack;
    logic [31:0]                 m_rdata;
    logic [31:0]                 s_addr;
    logic [31:0]                 s_wdata;
    logic                        s_we;
    logic                        s_re;
    logic                        s_ack;
    logic [31:0]                 s_rdata;
    logic                        timeout_err;

    // Arbiter side: serves the requesters and drives the shared bus.
    modport slave (
        input  m_req, m_we, m_re, m_addr, m_wdata, s_ack, s_rdata,
        output m_gnt, m_ack, m_rdata, s_addr, s_wdata, s_we, s_re, timeout_err
    );

    // Environment side: requesters plus the OR-combined peripherals.
    modport master (
        output m_req, m_we, m_re, m_addr, m_wdata, s_ack, s_rdata,
        input  m_gnt, m_ack, m_rdata, s_addr, s_wdata, s_we, s_re, timeout_err
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared IO bus; IO_BUS_ARBITER_TIMEOUT_EN adds a slave timeout.
// Latency: grant on the sampling edge, m_ack one cycle after s_ack (3 cycles minimum per transfer).
// Backpressure: BUSY holds until s_ack (or timeout); DONE never samples requests.
module io_bus_arbiter #(
    parameter int NR_OF_MASTERS  = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst,
    io_bus_arbiter_if.slave bus
);
    localparam int N  = NR_OF_MASTERS;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] win_q;
    logic [N-1:0]  eff;
    logic          any_req;
    logic          timeout_hit;

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'((v >= N) ? v - N : v);
    endfunction

    // A request counts only if it carries a read or write strobe.
    assign eff = bus.m_req & (bus.m_we | bus.m_re);

    // Search from ptr upward; iterating downward lets the lowest offset win.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            if (eff[wrap(int'(ptr) + off)]) begin
                win     = wrap(int'(ptr) + off);
                any_req = 1'b1;
            end
        end
    end

`ifdef IO_BUS_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] busy_cnt;

    assign timeout_hit = (state == BUSY) && !bus.s_ack && (busy_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Busy-cycle counter: parked at zero outside BUSY so it is clear on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= '0;
        end else if (state == BUSY) begin
            busy_cnt <= busy_cnt + CW'(1);
        end else begin
            busy_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (bus.s_ack || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered bus outputs, grant/ack and the rotating priority pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr             <= '0;
            win_q           <= '0;
            bus.m_gnt       <= '0;
            bus.m_ack       <= '0;
            bus.m_rdata     <= '0;
            bus.s_addr      <= '0;
            bus.s_wdata     <= '0;
            bus.s_we        <= 1'b0;
            bus.s_re        <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.m_ack       <= '0;
            bus.timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win_q       <= win;
                        bus.m_gnt   <= N'(1) << win;
                        bus.s_addr  <= bus.m_addr[int'(win)*32 +: 32];
                        bus.s_wdata <= bus.m_wdata[int'(win)*32 +: 32];
                        // Write wins when both strobes are set.
                        bus.s_we    <= bus.m_we[win];
                        bus.s_re    <= bus.m_re[win] & ~bus.m_we[win];
                    end
                end
                BUSY: begin
                    if (bus.s_ack || timeout_hit) begin
                        bus.m_ack       <= N'(1) << win_q;
                        bus.m_rdata     <= (bus.s_ack && bus.s_re) ? bus.s_rdata : 32'h0;
                        bus.timeout_err <= timeout_hit;
                        bus.m_gnt       <= '0;
                        bus.s_we        <= 1'b0;
                        bus.s_re        <= 1'b0;
                        ptr             <= wrap(int'(win_q) + 1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed scenarios followed by randomized traffic.
// Expected grants, bus values and read data come from a transaction-level model in this file.
// Timeout scenario is exercised when IO_BUS_ARBITER_TIMEOUT_EN is defined; otherwise BUSY stalling is checked.
module tb_io_bus_arbiter;
    localparam int NM = 2;

    logic clk;
    logic rst;
    int   npass;
    int   ntotal;
    int   mptr;
    logic [31:0] exp_rdata;

    io_bus_arbiter_if #(.NR_OF_MASTERS(NM)) bus ();

    io_bus_arbiter #(.NR_OF_MASTERS(NM), .TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Model arbitration rule: first effective request at or above mptr, wrapping.
    function automatic int pick(input logic [NM-1:0] eff);
        for (int off = 0; off < NM; off++) begin
            if (eff[(mptr + off) % NM]) return (mptr + off) % NM;
        end
        return -1;
    endfunction

    function automatic logic [31:0] onehot(input int i);
        logic [31:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_m(input int i, input bit r, input bit we, input bit re,
                         input logic [31:0] a, input logic [31:0] d);
        bus.m_req[i]           = r;
        bus.m_we[i]            = we;
        bus.m_re[i]            = re;
        bus.m_addr[i*32 +: 32]  = a;
        bus.m_wdata[i*32 +: 32] = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(bus.m_gnt), 0);
        chk({tag, "_ack"}, 32'(bus.m_ack), 0);
        chk({tag, "_rdata"}, bus.m_rdata, 0);
        chk({tag, "_saddr"}, bus.s_addr, 0);
        chk({tag, "_swdata"}, bus.s_wdata, 0);
        chk({tag, "_swe"}, 32'(bus.s_we), 0);
        chk({tag, "_sre"}, 32'(bus.s_re), 0);
        chk({tag, "_terr"}, 32'(bus.timeout_err), 0);
    endtask

    // One transaction from an IDLE cycle (called just after a negedge).
    // mode 0: drop all requests at m_ack, 1: keep all, 2: drop only the winner.
    task automatic run_txn(input int waits, input logic [31:0] rd, input int mode);
        int w;
        logic [31:0] ea, ed;
        logic ewe, ere;
        w = pick(bus.m_req & (bus.m_we | bus.m_re));
        if (w < 0) begin
            @(negedge clk);
            chk("idle_gnt", 32'(bus.m_gnt), 0);
            chk("idle_swe_sre", {30'b0, bus.s_we, bus.s_re}, 0);
            return;
        end
        ea  = bus.m_addr[w*32 +: 32];
        ed  = bus.m_wdata[w*32 +: 32];
        ewe = bus.m_we[w];
        ere = bus.m_re[w] & ~bus.m_we[w];
        @(negedge clk);
        for (int c = 0; c <= waits; c++) begin
            chk("busy_gnt", 32'(bus.m_gnt), onehot(w));
            chk("busy_saddr", bus.s_addr, ea);
            chk("busy_swdata", bus.s_wdata, ed);
            chk("busy_swe", 32'(bus.s_we), 32'(ewe));
            chk("busy_sre", 32'(bus.s_re), 32'(ere));
            chk("busy_ack", 32'(bus.m_ack), 0);
            // Inputs change during BUSY must not leak onto the bus.
            bus.m_addr[w*32 +: 32]  = $urandom;
            bus.m_wdata[w*32 +: 32] = $urandom;
            bus.s_ack   = (c == waits);
            bus.s_rdata = (c == waits) ? rd : $urandom;
            @(negedge clk);
        end
        bus.s_ack   = 1'b1;
        bus.s_rdata = $urandom;
        exp_rdata   = ere ? rd : 32'h0;
        mptr        = (w + 1) % NM;
        chk("done_ack", 32'(bus.m_ack), onehot(w));
        chk("done_rdata", bus.m_rdata, exp_rdata);
        chk("done_gnt", 32'(bus.m_gnt), 0);
        chk("done_swe_sre", {30'b0, bus.s_we, bus.s_re}, 0);
        chk("done_terr", 32'(bus.timeout_err), 0);
        if (mode == 0) bus.m_req = '0;
        else if (mode == 2) bus.m_req[w] = 1'b0;
        @(negedge clk);
        bus.s_ack   = 1'b0;
        bus.s_rdata = '0;
        chk("post_ack", 32'(bus.m_ack), 0);
        chk("post_rdata_hold", bus.m_rdata, exp_rdata);
    endtask

    initial begin
        int stall;
        npass     = 0;
        ntotal    = 0;
        mptr      = 0;
        exp_rdata = '0;
        rst         = 1'b1;
        bus.m_req   = '0;
        bus.m_we    = '0;
        bus.m_re    = '0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.s_ack   = 1'b0;
        bus.s_rdata = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single read, zero-wait slave.
        set_m(0, 1, 0, 1, 32'h4000_0010, 32'h0);
        run_txn(0, 32'hDEAD_BEEF, 0);

        // Both strobes: transfer is a write, read data returns 0.
        set_m(1, 1, 1, 1, 32'h4000_0100, 32'h1234_5678);
        run_txn(0, 32'hCAFE_F00D, 0);

        // Contention: both masters hold requests, zero-wait slave.
        set_m(0, 1, 0, 1, 32'h4000_0200, 32'h0);
        set_m(1, 1, 0, 1, 32'h4000_0300, 32'h0);
        for (int k = 0; k < 4; k++) run_txn(0, 32'h1000_0000 + k, (k == 3) ? 0 : 1);

        // Wait states: ack in the fifth BUSY cycle.
        set_m(0, 1, 0, 1, 32'h4000_0400, 32'h0);
        run_txn(4, 32'h5555_AAAA, 0);

        // Request without strobes is ignored; s_ack in IDLE is ignored.
        set_m(0, 1, 0, 0, 32'h4000_0500, 32'h0);
        bus.s_ack   = 1'b1;
        bus.s_rdata = 32'hFFFF_FFFF;
        repeat (2) begin
            @(negedge clk);
            chk("nostrobe_gnt", 32'(bus.m_gnt), 0);
            chk("idle_sack_ack", 32'(bus.m_ack), 0);
            chk("idle_sack_rdata", bus.m_rdata, exp_rdata);
        end
        bus.s_ack   = 1'b0;
        bus.s_rdata = '0;
        bus.m_req   = '0;
        @(negedge clk);

`ifdef IO_BUS_ARBITER_TIMEOUT_EN
        // Timeout: no s_ack for 16 BUSY cycles.
        set_m(0, 1, 0, 1, 32'h4000_0600, 32'h0);
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            chk("to_busy_gnt", 32'(bus.m_gnt), 32'h1);
            chk("to_busy_ack", 32'(bus.m_ack), 0);
            @(negedge clk);
        end
        chk("to_ack", 32'(bus.m_ack), 32'h1);
        chk("to_err", 32'(bus.timeout_err), 1);
        chk("to_rdata", bus.m_rdata, 0);
        exp_rdata = '0;
        mptr      = 1;
        bus.m_req = '0;
        @(negedge clk);
        chk("to_err_pulse", 32'(bus.timeout_err), 0);
        stall = 5;
`else
        stall = 20;
`endif
        // Make master 0 the most recent winner, so ptr points at master 1.
        set_m(0, 1, 0, 1, 32'h4000_0700, 32'h0);
        run_txn(0, 32'h7777_0000, 0);

        // Master 1 enters BUSY and the slave never answers; then reset mid-BUSY.
        set_m(1, 1, 0, 1, 32'h4000_0800, 32'h0);
        @(negedge clk);
        for (int c = 0; c < stall; c++) begin
            chk("stall_gnt", 32'(bus.m_gnt), 32'h2);
            chk("stall_sre", 32'(bus.s_re), 1);
            chk("stall_ack", 32'(bus.m_ack), 0);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst       = 1'b0;
        bus.m_req = '0;
        mptr      = 0;
        exp_rdata = '0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_noack", 32'(bus.m_ack), 0);
        end
        // After reset master 0 must win the contention.
        set_m(0, 1, 0, 1, 32'h4000_0900, 32'h0);
        set_m(1, 1, 0, 1, 32'h4000_0A00, 32'h0);
        chk("rst_ptr_winner", 32'(pick(bus.m_req & (bus.m_we | bus.m_re))), 0);
        run_txn(0, 32'h9999_0000, 0);

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NM; i++) begin
                if (!(bus.m_req[i] && (bus.m_we[i] || bus.m_re[i]))) begin
                    if ($urandom_range(0, 9) < 6)
                        set_m(i, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
                    else
                        bus.m_req[i] = 1'b0;
                end
            end
            run_txn($urandom_range(0, 4), $urandom, 2);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
